// File: rtl/irq_event_latch.sv
// irq_event_latch: collects level IRQs from up to 16 timers into one CPU
// interrupt line. Rising edges latch pending bits; software masks them,
// reads a priority-encoded ACTIVE word and clears them with W1C writes.
// Each source has a saturating counter of edges that arrived while it was
// still pending (timer overruns).
//
// Optional build macro IRQ_EVENT_TIMESTAMP_EN adds a free-running cycle
// counter, captured whenever irq rises, and readable at word addresses 6/7.
// The high half is taken from a shadow loaded by the addr-6 read, so a
// low/high read pair is coherent. Without the macro addr 6/7 read 0.

module irq_event_latch #(
  parameter int N_SRC  = 4,
  parameter int MISS_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq
);

  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  logic              wr;
  logic              rd;
  logic [N_SRC-1:0]  irq_in_q;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  w1c;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  act;
  logic [3:0]        act_idx;
  logic [3:0]        sel_q, sel_d;
  logic [MISS_W-1:0] miss_q [N_SRC];
  logic [MISS_W-1:0] miss_d [N_SRC];
  logic [15:0]       miss_rd;
  logic [15:0]       ts_rd;
  logic [15:0]       rd_mux;
  logic [15:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic              unused_wdata;

  assign wr   = chipselect & ~write_n;
  assign rd   = chipselect & write_n;
  assign rise = irq_in & ~irq_in_q;
  assign w1c  = (wr && address == 3'd0) ? writedata[N_SRC-1:0] : '0;

  // Only the low N_SRC bits of writedata feed register state.
  assign unused_wdata = ^writedata;

  // Pending/mask/select next state; a rise beats a same-cycle W1C.
  always_comb begin
    pending_d = (pending_q & ~w1c) | rise;
    mask_d    = mask_q;
    sel_d     = sel_q;
    if (wr && address == 3'd1) mask_d = writedata[N_SRC-1:0];
    if (wr && address == 3'd3) sel_d  = writedata[3:0];
    irq_d     = |(pending_d & mask_d);
  end

  // Missed-event counters: saturating increment, write-clear has priority.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      miss_d[i] = miss_q[i];
      if (wr && address == 3'd4 && sel_q == 4'(i)) begin
        miss_d[i] = '0;
      end else if (rise[i] && pending_q[i] && !w1c[i] && miss_q[i] != MISS_MAX) begin
        miss_d[i] = miss_q[i] + 1'b1;
      end
    end
  end

  // Lowest-index active source and the selected miss counter.
  always_comb begin
    act     = pending_q & mask_q;
    act_idx = 4'd0;
    miss_rd = 16'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) act_idx = 4'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_q == 4'(i)) miss_rd = 16'(miss_q[i]);
    end
  end

`ifdef IRQ_EVENT_TIMESTAMP_EN
  logic [31:0] cnt_q;
  logic [31:0] ts_q;
  logic [15:0] shadow_q;

  // Free-running counter, capture on irq rise, shadow load on low-half read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      ts_q     <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (irq_d && !irq_q) ts_q <= cnt_q;
      if (rd && address == 3'd6) shadow_q <= ts_q[31:16];
    end
  end

  assign ts_rd = (address == 3'd6) ? ts_q[15:0] : shadow_q;
`else
  assign ts_rd = 16'd0;
`endif

  // Register read mux; readdata only updates on a read access.
  always_comb begin
    rd_mux = 16'd0;
    case (address)
      3'd0:    rd_mux = 16'(pending_q);
      3'd1:    rd_mux = 16'(mask_q);
      3'd2:    rd_mux = {|act, 11'd0, act_idx};
      3'd3:    rd_mux = {12'd0, sel_q};
      3'd4:    rd_mux = miss_rd;
      3'd5:    rd_mux = 16'(irq_in_q);
      default: rd_mux = ts_rd;
    endcase
    readdata_d = rd ? rd_mux : readdata_q;
  end

  // Main state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in_q   <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      for (int i = 0; i < N_SRC; i++) miss_q[i] <= '0;
    end else begin
      irq_in_q   <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < N_SRC; i++) miss_q[i] <= miss_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_irq_event_latch.sv
// Bench for irq_event_latch (default N_SRC=4, MISS_W=8): directed steps from
// the test plan followed by random bus/IRQ traffic, all checked against a
// behavioural model built from per-source integer state.

module tb_irq_event_latch;

  localparam int N    = 4;
  localparam int MW   = 8;
  localparam int MMAX = (1 << MW) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [15:0]  writedata = '0;
  logic [15:0]  readdata;
  logic [N-1:0] irq_in = '0;
  logic         irq;

  always #5 clk = ~clk;

  irq_event_latch #(.N_SRC(N), .MISS_W(MW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  int n_pass = 0;
  int n_tot  = 0;

  int          m_pend [N];
  int          m_miss [N];
  int          m_prev [N];
  int          m_mask;
  int          m_sel;
  logic [15:0] m_rd;
  logic        m_irq;
  logic [N-1:0] cur_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_miss[i] = 0;
      m_prev[i] = 0;
    end
    m_mask = 0;
    m_sel  = 0;
    m_rd   = '0;
    m_irq  = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input int a);
    logic [15:0] v;
    bit found;
    v = '0;
    found = 0;
    case (a)
      0: for (int i = 0; i < N; i++) v[i] = (m_pend[i] != 0);
      1: v = 16'(m_mask);
      2: for (int i = 0; i < N; i++)
           if (!found && m_pend[i] != 0 && ((m_mask >> i) & 1) != 0) begin
             v = 16'h8000 | 16'(i);
             found = 1;
           end
      3: v = 16'(m_sel);
      4: if (m_sel < N) v = 16'(m_miss[m_sel]);
      5: for (int i = 0; i < N; i++) v[i] = (m_prev[i] != 0);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input int a, input bit cs, input bit wn,
                            input logic [15:0] wd, input logic [N-1:0] inp);
    bit wr;
    bit rise, clr, mclr;
    wr = cs && !wn;
    if (cs && wn) m_rd = model_read(a);
    for (int i = 0; i < N; i++) begin
      rise = inp[i] && (m_prev[i] == 0);
      clr  = wr && a == 0 && wd[i];
      mclr = wr && a == 4 && m_sel == i;
      if (rise) begin
        if (m_pend[i] != 0 && !clr && m_miss[i] < MMAX) m_miss[i]++;
        m_pend[i] = 1;
      end else if (clr) begin
        m_pend[i] = 0;
      end
      if (mclr) m_miss[i] = 0;
      m_prev[i] = inp[i] ? 1 : 0;
    end
    if (wr && a == 1) m_mask = int'(wd) & ((1 << N) - 1);
    if (wr && a == 3) m_sel = int'(wd) & 15;
    m_irq = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] != 0 && ((m_mask >> i) & 1) != 0) m_irq = 1'b1;
  endtask

  task automatic step(input int a, input bit cs, input bit wn,
                      input logic [15:0] wd, input logic [N-1:0] inp, input string tag);
    address    = a[2:0];
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    irq_in     = inp;
    @(posedge clk);
    model_step(a, cs, wn, wd, inp);
    #1;
    chk({tag, " irq"}, {15'd0, irq}, {15'd0, m_irq});
    chk({tag, " readdata"}, readdata, m_rd);
  endtask

  task automatic idle(input string tag);
    step(0, 1'b0, 1'b1, 16'd0, cur_in, tag);
  endtask

  task automatic bus_wr(input int a, input logic [15:0] d, input string tag);
    step(a, 1'b1, 1'b0, d, cur_in, tag);
  endtask

  task automatic bus_rd(input int a, input logic [15:0] exp, input string tag);
    step(a, 1'b1, 1'b1, 16'd0, cur_in, tag);
    chk({tag, " const"}, readdata, exp);
  endtask

  initial begin
    int op, a;
    logic [15:0] d;

    // Reset with irq_in[1] already high.
    model_reset();
    cur_in  = 4'b0010;
    irq_in  = cur_in;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset irq", {15'd0, irq}, 16'd0);
    chk("reset readdata", readdata, 16'd0);
    reset_n = 1'b1;
    idle("rel");
    bus_rd(0, 16'h0002, "pend_after_rel");
    chk("irq masked", {15'd0, irq}, 16'd0);
    bus_wr(1, 16'h0002, "mask_wr");
    chk("irq after mask", {15'd0, irq}, 16'd1);
    bus_rd(2, 16'h8001, "active_1");

    // Priority encode and W1C.
    cur_in = 4'b0000;
    bus_wr(0, 16'h0002, "clr1");
    bus_wr(1, 16'h000F, "mask_f");
    cur_in = 4'b1001;
    idle("pulse30");
    cur_in = 4'b0000;
    idle("pulse30_lo");
    bus_rd(2, 16'h8000, "active_0");
    bus_wr(0, 16'h0001, "w1c_0");
    bus_rd(2, 16'h8003, "active_3");
    bus_wr(0, 16'h0008, "w1c_3");
    chk("irq cleared", {15'd0, irq}, 16'd0);
    bus_rd(2, 16'h0000, "active_none");

    // Saturating miss counter.
    for (int k = 0; k < 300; k++) begin
      cur_in = 4'b0100;
      idle("miss_hi");
      cur_in = 4'b0000;
      idle("miss_lo");
    end
    bus_wr(3, 16'h0002, "sel2");
    bus_rd(4, 16'd255, "miss_sat");
    bus_wr(4, 16'h0000, "miss_clr");
    bus_rd(4, 16'd0, "miss_after_clr");

    // W1C and rise on the same bit in the same cycle.
    cur_in = 4'b0100;
    step(0, 1'b1, 1'b0, 16'h0004, cur_in, "w1c_vs_rise");
    bus_rd(0, 16'h0004, "pend_set_wins");
    bus_rd(4, 16'd0, "miss_not_inc");
    cur_in = 4'b0000;
    idle("lo");

    // Out-of-range select reads 0 even when counters are nonzero.
    for (int k = 0; k < 4; k++) begin
      cur_in = 4'b0010;
      idle("m1_hi");
      cur_in = 4'b0000;
      idle("m1_lo");
    end
    bus_wr(3, 16'h0001, "sel1");
    bus_rd(4, 16'd3, "miss1");
    bus_wr(3, 16'h0005, "sel5");
    bus_rd(3, 16'h0005, "sel_rb");
    bus_rd(4, 16'd0, "miss_sel_oob");
    bus_rd(5, 16'h0000, "raw");

    // Async reset mid-operation.
    cur_in = 4'b1111;
    idle("all_hi");
    cur_in = 4'b0000;
    idle("all_lo");
    bus_rd(1, 16'h000F, "mask_rb");
    chk("irq all", {15'd0, irq}, 16'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async irq", {15'd0, irq}, 16'd0);
    chk("async readdata", readdata, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus_rd(0, 16'h0000, "pend_post_rst");
    bus_rd(1, 16'h0000, "mask_post_rst");
    bus_rd(3, 16'h0000, "sel_post_rst");

`ifndef IRQ_EVENT_TIMESTAMP_EN
    bus_wr(1, 16'h000F, "mask_f2");
    bus_rd(1, 16'h000F, "mask_rb2");
    bus_rd(6, 16'h0000, "ts_lo_absent");
    bus_rd(1, 16'h000F, "mask_rb3");
    bus_rd(7, 16'h0000, "ts_hi_absent");
`endif

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      cur_in = N'($urandom);
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 5));
      d  = 16'($urandom);
      if (op == 0) idle("rnd_idle");
      else if (op == 1) step(a, 1'b1, 1'b1, 16'd0, cur_in, "rnd_rd");
      else step(int'($urandom_range(0, 7)), 1'b1, 1'b0, d, cur_in, "rnd_wr");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
